shift_reg: RTL and testbench
============================

Name: shift_reg

Overview:
- Parallel-load, serial-shift register used as the SPI data path. On the TX side it drives MOSI/MISO from `serial_out`; on the RX side it captures `serial_in`.
- Data is loaded in parallel, then shifted one bit per enabled clock, MSB first by default.
- The full register contents are always visible on `d_out`.
- Instantiated by the SPI master/slave control logic, which owns the timing of `load_en` and `shift_en`.

Parameters:
- DATA_LEN, default `DATA_LEN from spi_defines.vh (8), register width in bits; legal range 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d_in  input  DATA_LEN  parallel load data.
- load_en  input  1  load `d_in` into the register on this edge.
- shift_en  input  1  shift the register by one bit on this edge.
- serial_in  input  1  bit shifted into the vacated end of the register.
- serial_out  output  1  bit currently presented at the shift-out end of the register.
- d_out  output  DATA_LEN  current register contents.

Behaviour:
- Single internal register `sreg[DATA_LEN-1:0]`. All updates occur on the rising edge of `clk`.
- Priority per edge: `rst` > `load_en` > `shift_en` > hold.
  - rst=1: sreg <= 0. So d_out=0 and serial_out=0 from the following edge.
  - load_en=1: sreg <= d_in. `shift_en` is ignored on that edge; load wins.
  - shift_en=1 (MSB-first): sreg <= {sreg[DATA_LEN-2:0], serial_in}.
  - Otherwise: sreg holds.
- Output decoding:
  - d_out = sreg, combinational from the register; no extra pipeline stage.
  - serial_out = sreg[DATA_LEN-1] in MSB-first mode, combinational from the register.
- Latency:
  - The first bit (MSB of `d_in`) appears on `serial_out` immediately after the load edge.
  - Each subsequent bit appears after each shift edge.
  - After DATA_LEN shifts, the register holds exactly the DATA_LEN `serial_in` samples, in arrival order with the first sample at the MSB. This gives full-duplex TX/RX in one register.
- Boundaries:
  - Shifting more than DATA_LEN times keeps shifting; there is no counter or saturation.
  - Reset mid-shift clears immediately at the next edge, regardless of `load_en` or `shift_en`.
  - Held enables shift continuously, one bit per clock.
  - `d_in` is sampled only on load edges.
- No X propagation from unused inputs: when not shifting, `serial_in` does not affect state.

Optional Feature:
- Macro: SHIFT_REG_LSB_FIRST_EN.
- Defined:
  - Shift is sreg <= {serial_in, sreg[DATA_LEN-1:1]}.
  - serial_out = sreg[0].
  - Received data lands MSB-last, i.e. the first sample ends at bit 0.
- Not defined (default): MSB-first behaviour exactly as specified above.
- Reset, load, priority and `d_out` behaviour are identical in both modes.

Test Plan:
- Reset: rst=1 for one edge with arbitrary prior contents -> d_out=8'h00, serial_out=0. Deassert rst with no enables -> value held.
- Load: d_in=8'b10110011, load_en=1 for one edge -> d_out=8'hB3, serial_out=1.
- TX shift, serial_in=0, shift_en=1 for 8 edges after loading 8'hB3:
  - d_out after each edge: 66, CC, 98, 30, 60, C0, 80, 00.
  - serial_out after each edge: 0, 1, 1, 0, 0, 1, 1, 0.
- RX shift: load 8'h00, then shift 8 edges with serial_in driven 1,0,1,0,0,1,0,1 -> d_out=8'hA5.
- Priority: load_en=1 and shift_en=1 with d_in=8'h5A -> d_out=8'h5A, no shift. rst=1 with load_en=1 -> d_out=8'h00.
- Hold and LSB mode:
  - Load 8'hB3 with shift_en=0 for 5 edges -> unchanged.
  - With SHIFT_REG_LSB_FIRST_EN, load 8'hB3 and shift with serial_in=0 -> serial_out sequence 1,1,0,0,1,1,0,1; d_out after the first shift = 8'h59.

Source files
------------

// File: rtl/shift_reg.sv
// Parallel-load, serial-shift register forming the SPI data path (TX via serial_out, RX via serial_in).
// Define SHIFT_REG_LSB_FIRST_EN to shift LSB first; the default build shifts MSB first.

`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module shift_reg #(
  parameter int DATA_LEN = `DATA_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] d_in,
  input  logic                load_en,
  input  logic                shift_en,
  input  logic                serial_in,
  output logic                serial_out,
  output logic [DATA_LEN-1:0] d_out
);

  logic [DATA_LEN-1:0] sreg_q;
  logic [DATA_LEN-1:0] sreg_d;
  logic [DATA_LEN-1:0] shifted;

  // The vacated end takes serial_in, so after DATA_LEN shifts the register holds exactly the received word.
`ifdef SHIFT_REG_LSB_FIRST_EN
  assign shifted    = {serial_in, sreg_q[DATA_LEN-1:1]};
  assign serial_out = sreg_q[0];
`else
  assign shifted    = {sreg_q[DATA_LEN-2:0], serial_in};
  assign serial_out = sreg_q[DATA_LEN-1];
`endif

  always_comb begin
    sreg_d = sreg_q;
    if (load_en) begin
      sreg_d = d_in;
    end else if (shift_en) begin
      sreg_d = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign d_out = sreg_q;

endmodule

// File: tb/tb_shift_reg.sv
// Scoreboard bench for shift_reg: stimulus pushes expected register state, a negedge monitor pops and compares.
// Expected shift sequences follow SHIFT_REG_LSB_FIRST_EN when it is defined.

module tb_shift_reg;

  typedef struct {
    string      name;
    logic [7:0] expD;
    logic       expS;
  } expect_t;

  logic       clk;
  logic       rst;
  logic [7:0] d_in;
  logic       load_en;
  logic       shift_en;
  logic       serial_in;
  logic       serial_out;
  logic [7:0] d_out;

  expect_t scoreboard[$];
  int      checks;
  int      errors;

  // Hand-computed register contents for the TX shift (from 8'hB3, serial_in=0),
  // the RX shift (from 8'h00, serial_in 1,0,1,0,0,1,0,1) and one extra shift with serial_in=1.
`ifdef SHIFT_REG_LSB_FIRST_EN
  logic [7:0] txTable [8] = '{8'h59, 8'h2C, 8'h16, 8'h0B, 8'h05, 8'h02, 8'h01, 8'h00};
  logic [7:0] rxTable [8] = '{8'h80, 8'h40, 8'hA0, 8'h50, 8'h28, 8'h94, 8'h4A, 8'hA5};
  logic [7:0] overShift   = 8'hD2;
`else
  logic [7:0] txTable [8] = '{8'h66, 8'hCC, 8'h98, 8'h30, 8'h60, 8'hC0, 8'h80, 8'h00};
  logic [7:0] rxTable [8] = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h14, 8'h29, 8'h52, 8'hA5};
  logic [7:0] overShift   = 8'h4B;
`endif
  logic       rxBits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  shift_reg #(.DATA_LEN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .load_en   (load_en),
    .shift_en  (shift_en),
    .serial_in (serial_in),
    .serial_out(serial_out),
    .d_out     (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The bit presented at the shift-out end of the expected word.
  function automatic logic outBit(input logic [7:0] v);
`ifdef SHIFT_REG_LSB_FIRST_EN
    return v[0];
`else
    return v[7];
`endif
  endfunction

  task automatic applyStimulus(input string name, input logic r, input logic ld, input logic sh,
                               input logic [7:0] din, input logic sin, input logic [7:0] expD);
    expect_t e;
    rst       = r;
    load_en   = ld;
    shift_en  = sh;
    d_in      = din;
    serial_in = sin;
    @(posedge clk);
    #1;
    e.name = name;
    e.expD = expD;
    e.expS = outBit(expD);
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    checks++;
    if (d_out !== e.expD || serial_out !== e.expS) begin
      errors++;
      $display("[TB] FAIL %s: d_out=%h serial_out=%b, expected d_out=%h serial_out=%b",
               e.name, d_out, serial_out, e.expD, e.expS);
    end
  endtask

  // Monitor: every registered update is compared half a cycle after its edge.
  always @(negedge clk) begin
    if (scoreboard.size() > 0) begin
      checkOutput(scoreboard.pop_front());
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    d_in      = 8'h00;
    serial_in = 1'b0;

    applyStimulus("prior_load",  1'b0, 1'b1, 1'b0, 8'hC7, 1'b0, 8'hC7);
    applyStimulus("reset",       1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h00);
    applyStimulus("reset_hold",  1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h00);
    applyStimulus("load_b3",     1'b0, 1'b1, 1'b0, 8'hB3, 1'b0, 8'hB3);
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("tx_shift%0d", i), 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, txTable[i]);
    end

    applyStimulus("load_00",     1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("rx_shift%0d", i), 1'b0, 1'b0, 1'b1, 8'h3C, rxBits[i], rxTable[i]);
    end
    applyStimulus("over_shift",  1'b0, 1'b0, 1'b1, 8'h00, 1'b1, overShift);

    applyStimulus("load_wins",   1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 8'h5A);
    applyStimulus("rst_vs_load", 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00);
    applyStimulus("load_b3_b",   1'b0, 1'b1, 1'b0, 8'hB3, 1'b0, 8'hB3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b0, 8'h11 * (i + 1), 1'b1, 8'hB3);
    end
    applyStimulus("shift_pre",   1'b0, 1'b0, 1'b1, 8'h00, 1'b0, txTable[0]);
    applyStimulus("rst_midshift",1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h00);

    rst      = 1'b0;
    shift_en = 1'b0;
    load_en  = 1'b0;
    for (int i = 0; i < 10 && scoreboard.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (scoreboard.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left unchecked, expected 0", scoreboard.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
